// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game controller and its timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CLR_CNT1 = 3'd2,
    ST_START    = 3'd3,
    ST_RESULT   = 3'd4,
    ST_CLR_CNT2 = 3'd5,
    ST_FOUL     = 3'd6,
    ST_ILLEGAL  = 3'd7
  } state_e;

  localparam logic [13:0] DELAY_MIN_DEF = 14'd1500;
  localparam int unsigned LFSR_W        = 13;
  localparam logic [12:0] LFSR_SEED_DEF = 13'h1ACE;
  localparam logic [9:0]  REACT_MAX     = 10'd999;

endpackage

// File: rtl/lfsr13.sv
// 13-bit Fibonacci LFSR, x^13+x^4+x^3+x+1, advancing every clock.
module lfsr13
  import reaction_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: round sequencing, result/best tracking, random delay.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter logic [13:0]       DELAY_MIN = DELAY_MIN_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_react,
  input  logic        signal_start,
  input  logic        signal_overflow,
  input  logic        signal_cleared,
  input  logic [9:0]  react_time,
  output logic [2:0]  machine_state,
  output logic [13:0] rand_num,
  output logic        led_go,
  output logic        foul,
  output logic        timeout,
  output logic        result_valid,
  output logic [9:0]  result,
  output logic [9:0]  best
);

  state_e            state_q, state_d;
  logic              start_prev_q, react_prev_q;
  logic              start_press, react_press;
  logic [LFSR_W-1:0] lfsr;
  logic [13:0]       rand_q, rand_d;
  logic [9:0]        result_q, result_d, best_q, best_d;
  logic              led_go_q, led_go_d, foul_q, foul_d;
  logic              timeout_q, timeout_d, valid_q, valid_d;

  lfsr13 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign start_press = btn_start & ~start_prev_q;
  assign react_press = btn_react & ~react_prev_q;

  always_comb begin
    state_d   = state_q;
    rand_d    = rand_q;
    result_d  = result_q;
    best_d    = best_q;
    foul_d    = foul_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE:     if (start_press) state_d = ST_CLR_CNT1;
      ST_CLR_CNT1: if (signal_cleared) state_d = ST_WAIT;
      ST_WAIT: begin
        if (react_press) begin
          state_d = ST_FOUL;
          foul_d  = 1'b1;
          valid_d = 1'b0;
        end else if (signal_start) begin
          state_d = ST_CLR_CNT2;
        end
      end
      ST_CLR_CNT2: if (signal_cleared) state_d = ST_START;
      ST_START: begin
        if (react_press) begin
          state_d   = ST_RESULT;
          result_d  = react_time;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          if (react_time < best_q) best_d = react_time;
        end else if (signal_overflow) begin
          state_d   = ST_RESULT;
          result_d  = REACT_MAX;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
        end
      end
      ST_RESULT, ST_FOUL: if (start_press) state_d = ST_CLR_CNT1;
      default:     state_d = ST_IDLE;
    endcase
    // Every entry into CLR_CNT1 comes from IDLE/RESULT/FOUL, so status clears here too.
    if (state_d == ST_CLR_CNT1 && state_q != ST_CLR_CNT1) begin
      rand_d    = {1'b0, lfsr} + DELAY_MIN;
      foul_d    = 1'b0;
      timeout_d = 1'b0;
      valid_d   = 1'b0;
    end
    led_go_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;
      react_prev_q <= 1'b1;
      rand_q       <= '0;
      result_q     <= '0;
      best_q       <= REACT_MAX;
      led_go_q     <= 1'b0;
      foul_q       <= 1'b0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= btn_start;
      react_prev_q <= btn_react;
      rand_q       <= rand_d;
      result_q     <= result_d;
      best_q       <= best_d;
      led_go_q     <= led_go_d;
      foul_q       <= foul_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
    end
  end

  assign machine_state = state_q;
  assign rand_num      = rand_q;
  assign led_go        = led_go_q;
  assign foul          = foul_q;
  assign timeout       = timeout_q;
  assign result_valid  = valid_q;
  assign result        = result_q;
  assign best          = best_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed self-checking bench for reaction_ctrl.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0, btn_react = 1'b0;
  logic        signal_start = 1'b0, signal_overflow = 1'b0, signal_cleared = 1'b0;
  logic [9:0]  react_time = '0;
  logic [2:0]  machine_state;
  logic [13:0] rand_num;
  logic        led_go, foul, timeout, result_valid;
  logic [9:0]  result, best;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [12:0] m_lfsr;
  logic [13:0] exp_rand;
  logic [6:0]  obs_f, exp_f;

  reaction_ctrl #(.DELAY_MIN(14'd1500), .LFSR_SEED(13'h1ACE)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_react(btn_react),
    .signal_start(signal_start), .signal_overflow(signal_overflow),
    .signal_cleared(signal_cleared), .react_time(react_time),
    .machine_state(machine_state), .rand_num(rand_num), .led_go(led_go),
    .foul(foul), .timeout(timeout), .result_valid(result_valid),
    .result(result), .best(best)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^13+x^4+x^3+x+1, seed on reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 13'h1ACE;
    else     m_lfsr <= {m_lfsr[11:0], m_lfsr[12] ^ m_lfsr[3] ^ m_lfsr[2] ^ m_lfsr[0]};
  end

  // {state, led_go, foul, timeout, result_valid}
  function automatic logic [6:0] flags();
    return {machine_state, led_go, foul, timeout, result_valid};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_start = 0; btn_react = 0;
    signal_start = 0; signal_overflow = 0; signal_cleared = 0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Start press from IDLE/RESULT/FOUL; captures expected rand_num from the model.
  task automatic press_start();
    btn_start = 1'b1;
    exp_rand = {1'b0, m_lfsr} + 14'd1500;
    step();
    btn_start = 1'b0;
  endtask

  // From CLR_CNT1: cleared -> WAIT, signal_start -> CLR_CNT2, cleared -> START.
  task automatic run_to_start();
    signal_cleared = 1'b1; step(); signal_cleared = 1'b0;
    signal_start = 1'b1;   step(); signal_start = 1'b0;
    signal_cleared = 1'b1; step(); signal_cleared = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (flags() !== 7'b000_0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", flags(), 7'b0);
    end
    checks++;
    if ({rand_num, result, best} !== {14'd0, 10'd0, 10'd999}) begin
      failures++; $display("FAIL reset_regs got=%0d/%0d/%0d exp=0/0/999", rand_num, result, best);
    end
  endtask

  task automatic test_normal_round();
    btn_react = 1'b1; step(); btn_react = 1'b0; step();
    checks++;
    if (machine_state !== 3'd0) begin
      failures++; $display("FAIL idle_react_ignored got=%0d exp=0", machine_state);
    end
    press_start();
    checks++;
    if ({machine_state, rand_num} !== {3'd2, exp_rand}) begin
      failures++; $display("FAIL normal_clr1 got=%0d/%0d exp=2/%0d", machine_state, rand_num, exp_rand);
    end
    step();
    checks++;
    if (machine_state !== 3'd2) begin
      failures++; $display("FAIL clr1_hold got=%0d exp=2", machine_state);
    end
    run_to_start();
    checks++;
    if (flags() !== {3'd3, 4'b1000}) begin
      failures++; $display("FAIL start_flags got=%b exp=%b", flags(), {3'd3, 4'b1000});
    end
    btn_react = 1'b1; react_time = 10'd250; step(); btn_react = 1'b0;
    exp_f = {3'd4, 4'b0001};
    checks++;
    if (flags() !== exp_f || result !== 10'd250 || best !== 10'd250) begin
      failures++; $display("FAIL normal_result got=%b/%0d/%0d exp=%b/250/250", flags(), result, best, exp_f);
    end
  endtask

  task automatic test_foul();
    do_reset();
    press_start();
    signal_cleared = 1'b1; step(); signal_cleared = 1'b0;
    btn_react = 1'b1; step(); btn_react = 1'b0;
    exp_f = {3'd6, 4'b0100};
    checks++;
    if (flags() !== exp_f || best !== 10'd999) begin
      failures++; $display("FAIL foul_state got=%b/%0d exp=%b/999", flags(), best, exp_f);
    end
    step();
    press_start();
    exp_f = {3'd2, 4'b0000};
    checks++;
    if (flags() !== exp_f || rand_num !== exp_rand) begin
      failures++; $display("FAIL foul_restart got=%b/%0d exp=%b/%0d", flags(), rand_num, exp_f, exp_rand);
    end
  endtask

  task automatic test_timeout();
    run_to_start();
    signal_overflow = 1'b1; react_time = 10'd999; step(); signal_overflow = 1'b0;
    exp_f = {3'd4, 4'b0010};
    checks++;
    if (flags() !== exp_f || result !== 10'd999 || best !== 10'd999) begin
      failures++; $display("FAIL timeout got=%b/%0d/%0d exp=%b/999/999", flags(), result, best, exp_f);
    end
  endtask

  task automatic test_coincide();
    step();
    press_start();
    signal_cleared = 1'b1; step(); signal_cleared = 1'b0;
    btn_react = 1'b1; signal_start = 1'b1; step(); btn_react = 1'b0; signal_start = 1'b0;
    checks++;
    if (flags() !== {3'd6, 4'b0100}) begin
      failures++; $display("FAIL coincide_start got=%b exp=%b", flags(), {3'd6, 4'b0100});
    end
    step();
    press_start();
    run_to_start();
    btn_react = 1'b1; signal_overflow = 1'b1; react_time = 10'd999; step();
    btn_react = 1'b0; signal_overflow = 1'b0;
    exp_f = {3'd4, 4'b0001};
    checks++;
    if (flags() !== exp_f || result !== 10'd999 || best !== 10'd999) begin
      failures++; $display("FAIL coincide_overflow got=%b/%0d/%0d exp=%b/999/999", flags(), result, best, exp_f);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] times [3];
    logic [9:0] bests [3];
    times = '{10'd250, 10'd300, 10'd180};
    bests = '{10'd250, 10'd250, 10'd180};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press_start();
      checks++;
      if (rand_num !== exp_rand) begin
        failures++; $display("FAIL b2b_rand[%0d] got=%0d exp=%0d", i, rand_num, exp_rand);
      end
      run_to_start();
      btn_react = 1'b1; react_time = times[i]; step(); btn_react = 1'b0;
      checks++;
      if (result !== times[i] || best !== bests[i] || result_valid !== 1'b1) begin
        failures++; $display("FAIL b2b_best[%0d] got=%0d/%0d exp=%0d/%0d", i, result, best, times[i], bests[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_round();
    press_start();
    run_to_start();
    btn_react = 1'b1; rst = 1'b1; step();
    checks++;
    if (flags() !== 7'b000_0000 || best !== 10'd999 || result !== 10'd0) begin
      failures++; $display("FAIL midround_reset got=%b/%0d/%0d exp=%b/999/0", flags(), best, result, 7'b0);
    end
    rst = 1'b0; step();
    press_start();
    run_to_start();
    step(); step();
    checks++;
    if (machine_state !== 3'd3) begin
      failures++; $display("FAIL held_react_no_press got=%0d exp=3", machine_state);
    end
    btn_react = 1'b0; step();
    btn_react = 1'b1; react_time = 10'd400; step(); btn_react = 1'b0;
    checks++;
    if (machine_state !== 3'd4 || result !== 10'd400 || best !== 10'd400) begin
      failures++; $display("FAIL repress got=%0d/%0d/%0d exp=4/400/400", machine_state, result, best);
    end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_foul();
    test_timeout();
    test_coincide();
    test_back_to_back();
    test_reset_mid_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
